riscv_v_reduct_seq: RTL and testbench
=====================================

// Module: riscv_v_reduct_seq
// PURPOSE
// - Multi-cycle vector reduction unit for vred{sum,and,or,xor,max,maxu,min,minu}.vs in the vector execute stage.
// - Walks vs2 in LANE_W-bit chunks, from the chunk holding vstart up to the chunk holding vl-1, and folds each chunk into a SEW-wide accumulator seeded with vs1[0].
// - Supports vstart != 0, which the single-cycle ALU reduction path does not.
// - Handshaked in/out; the issue logic steers reductions here instead of the single-cycle ALU.
// PARAMETERS
// - VLEN    128  vector register width in bits.
// - ELEN    64   maximum SEW; width of scalar init and result.
// - LANE_W  64   bits consumed per ACCUM cycle; power of 2, ELEN <= LANE_W <= VLEN.
// PORTS
// - clk        in   1                  clock
// - rst        in   1                  reset, asynchronous, active-low
// - flush      in   1                  sync kill of the in-flight op
// - in_valid   in   1                  request valid
// - in_ready   out  1                  high only in IDLE
// - op         in   riscv_v_reduct_op_e  SUM/AND/OR/XOR/MAX/MAXU/MIN/MINU
// - sew        in   2                  0:8, 1:16, 2:32, 3:64 (must be <= ELEN)
// - vs2        in   VLEN               source vector
// - init       in   ELEN               vs1[0], low SEW bits used
// - mask       in   VLEN/8             bit i enables element i
// - use_mask   in   1                  0: all elements enabled
// - vl         in   $clog2(VLEN/8)+1   vector length in elements
// - vstart     in   $clog2(VLEN/8)     first element index
// - out_valid  out  1                  result valid
// - out_ready  in   1                  consumer accepts
// - res_data   out  ELEN               result; upper ELEN-SEW bits are zero
// - res_we     out  1                  0 when vstart >= vl (no vd write)
// BEHAVIOUR
// - Reset: FSM to IDLE; accumulator and all registered state 0; out_valid=0, res_data=0, res_we=0, in_ready=1.
// - Accept: in_valid & in_ready at edge T0. At T0, latch op, sew, vs2, masks, vl, vstart; acc<=init[SEW-1:0]; EPC = LANE_W/SEW.
// - Chunk range: first=floor(vstart/EPC), last=ceil(vl/EPC)-1, N=last-first+1.
// - FSM IDLE: on accept, go to ACCUM if vstart<vl, else DONE with res_we=0 and res_data=init zero-extended.
// - FSM ACCUM: one chunk per cycle, chunk counter from first to last. After last, go to DONE.
// - FSM DONE: out_valid=1, res_data/res_we held stable until out_ready, then IDLE. flush in DONE also goes to IDLE.
// - Latency: out_valid rises N+1 cycles after T0, or 1 cycle after T0 when N=0. Throughput is one op per N+2 cycles minimum.
// - Element i is active iff vstart <= i < vl and (!use_mask | mask[i]).
// - Inactive elements contribute the op identity:
//   - SUM/OR/XOR/MAXU: 0
//   - AND/MINU: all-ones
//   - MAX: signed minimum
//   - MIN: signed maximum
// - A chunk with no active elements leaves acc unchanged.
// - Arithmetic: SUM wraps mod 2^SEW. MAX/MIN compare signed at SEW; MAXU/MINU compare unsigned. The mask is applied before combining.
// - flush in ACCUM: go to IDLE next cycle; no out_valid for the killed op. flush in IDLE is a no-op.
// - flush and accept in the same cycle: flush wins; the request is not accepted.
// - Reset mid-op (rst low): immediately return to reset state.
// - in_ready=0 in ACCUM and DONE. Inputs are sampled only at accept, so they may change afterwards.
// STRUCTURE
// - riscv_v_pkg gets:
//   - riscv_v_reduct_op_e
//   - riscv_v_reduct_state_e {IDLE,ACCUM,DONE}
//   - function riscv_v_reduct_identity(op,sew)
//   - localparam for SEW encodings
// - Sub-module riscv_v_reduct_chunk (combinational): takes a LANE_W slice, active bits, op and sew. It returns the folded ELEN value via a log2(EPC)-level tree with per-SEW lane grouping. The parent combines this value with acc.
// - Parent holds the FSM, chunk counter, active-element mask generation and output registers.
// TESTING (VLEN=128, LANE_W=64, ELEN=64)
// - SUM, sew=2, vl=4, vstart=0, use_mask=0, vs2={4,3,2,1}, init=10 -> res_data=20, res_we=1; out_valid 3 cycles after accept (N=2).
// - MAXU, sew=0, vl=16, use_mask=1, mask=0x00FF, vs2 bytes 0..15 = 0x10+i, byte 15=0xFF -> res_data=0x17.
// - SUM, sew=1, vl=8, vstart=5, all elements 1, init=0 -> res_data=3; only chunk 1 walked (N=1), out_valid 2 cycles after accept.
// - vl=0 or vstart=vl=6 -> out_valid 1 cycle after accept, res_we=0, res_data=init.
// - MIN, sew=3, elements {0x8000_0000_0000_0000, 5}, init=7 -> 0x8000_0000_0000_0000. SUM of {0xFF,0x02} at sew=0 -> 0x01 (wrap).
// - out_ready low 5 cycles -> res_data stable and in_ready=0 throughout.
// - flush in cycle 1 of ACCUM -> IDLE next cycle, no out_valid.
// - rst asserted mid-ACCUM -> all outputs 0 and in_ready=1 at once.

Source files
------------

// File: rtl/riscv_v_reduct_seq_pkg.sv
// Shared types and helpers for the sequential vector reduction unit.
// Element values are carried in 64-bit containers and masked to the active SEW.
package riscv_v_pkg;

  localparam int unsigned RV_XW = 64;

  localparam logic [1:0] SEW_E8  = 2'd0;
  localparam logic [1:0] SEW_E16 = 2'd1;
  localparam logic [1:0] SEW_E32 = 2'd2;
  localparam logic [1:0] SEW_E64 = 2'd3;

  typedef enum logic [2:0] {
    RED_SUM  = 3'd0,
    RED_AND  = 3'd1,
    RED_OR   = 3'd2,
    RED_XOR  = 3'd3,
    RED_MAX  = 3'd4,
    RED_MAXU = 3'd5,
    RED_MIN  = 3'd6,
    RED_MINU = 3'd7
  } riscv_v_reduct_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } riscv_v_reduct_state_e;

  function automatic logic [RV_XW-1:0] riscv_v_sew_mask(input logic [1:0] sew);
    case (sew)
      SEW_E8:  return 64'h0000_0000_0000_00FF;
      SEW_E16: return 64'h0000_0000_0000_FFFF;
      SEW_E32: return 64'h0000_0000_FFFF_FFFF;
      default: return '1;
    endcase
  endfunction

  function automatic logic [RV_XW-1:0] riscv_v_sext(input logic [RV_XW-1:0] v,
                                                    input logic [1:0] sew);
    case (sew)
      SEW_E8:  return {{56{v[7]}}, v[7:0]};
      SEW_E16: return {{48{v[15]}}, v[15:0]};
      SEW_E32: return {{32{v[31]}}, v[31:0]};
      default: return v;
    endcase
  endfunction

  // Value that leaves any accumulator unchanged when folded in.
  function automatic logic [RV_XW-1:0] riscv_v_reduct_identity(input riscv_v_reduct_op_e op,
                                                               input logic [1:0] sew);
    logic [RV_XW-1:0] m;
    m = riscv_v_sew_mask(sew);
    case (op)
      RED_AND, RED_MINU: return m;
      RED_MAX:           return m ^ (m >> 1);
      RED_MIN:           return m >> 1;
      default:           return '0;
    endcase
  endfunction

  function automatic logic [RV_XW-1:0] riscv_v_reduct_combine(input riscv_v_reduct_op_e op,
                                                              input logic [1:0] sew,
                                                              input logic [RV_XW-1:0] a,
                                                              input logic [RV_XW-1:0] b);
    logic [RV_XW-1:0] m, au, bu, r;
    logic signed [RV_XW-1:0] as, bs;
    m  = riscv_v_sew_mask(sew);
    au = a & m;
    bu = b & m;
    as = $signed(riscv_v_sext(a, sew));
    bs = $signed(riscv_v_sext(b, sew));
    case (op)
      RED_SUM:  r = au + bu;
      RED_AND:  r = au & bu;
      RED_OR:   r = au | bu;
      RED_XOR:  r = au ^ bu;
      RED_MAX:  r = (as > bs) ? au : bu;
      RED_MAXU: r = (au > bu) ? au : bu;
      RED_MIN:  r = (as < bs) ? au : bu;
      default:  r = (au < bu) ? au : bu;
    endcase
    return r & m;
  endfunction

endpackage

// File: rtl/riscv_v_reduct_seq_if.sv
// Request/response bundle between the vector issue logic and the reduction unit.
interface riscv_v_reduct_seq_if
  import riscv_v_pkg::*;
#(
  parameter int unsigned VLEN = 128,
  parameter int unsigned ELEN = 64
) ();

  logic                          in_valid;
  logic                          in_ready;
  riscv_v_reduct_op_e            op;
  logic [1:0]                    sew;
  logic [VLEN-1:0]               vs2;
  logic [ELEN-1:0]               init;
  logic [VLEN/8-1:0]             mask;
  logic                          use_mask;
  logic [$clog2(VLEN/8):0]       vl;
  logic [$clog2(VLEN/8)-1:0]     vstart;
  logic                          out_valid;
  logic                          out_ready;
  logic [ELEN-1:0]               res_data;
  logic                          res_we;

  modport slave (
    input  in_valid, op, sew, vs2, init, mask, use_mask, vl, vstart, out_ready,
    output in_ready, out_valid, res_data, res_we
  );

  modport master (
    output in_valid, op, sew, vs2, init, mask, use_mask, vl, vstart, out_ready,
    input  in_ready, out_valid, res_data, res_we
  );

endinterface

// File: rtl/riscv_v_reduct_seq_chunk.sv
// Folds one LANE_W slice of vs2 into a single SEW-wide value; inactive lanes
// and lanes beyond the per-SEW element count are replaced by the op identity.
module riscv_v_reduct_chunk
  import riscv_v_pkg::*;
#(
  parameter int unsigned LANE_W = 64,
  parameter int unsigned ELEN   = 64
) (
  input  logic [LANE_W-1:0]   data_i,
  input  logic [LANE_W/8-1:0] act_i,
  input  riscv_v_reduct_op_e  op_i,
  input  logic [1:0]          sew_i,
  output logic [ELEN-1:0]     fold_o
);

  localparam int unsigned NB   = LANE_W / 8;
  localparam int unsigned LVLS = $clog2(NB);

  logic [LANE_W+RV_XW-1:0] pad;
  logic [RV_XW-1:0]        node [NB];
  logic [RV_XW-1:0]        ident;
  logic [RV_XW-1:0]        smask;
  int unsigned             epc;
  int unsigned             sh;

  assign pad = {{RV_XW{1'b0}}, data_i};

  // Padding with the identity lets one fixed-depth tree serve every SEW.
  always_comb begin
    ident = riscv_v_reduct_identity(op_i, sew_i);
    smask = riscv_v_sew_mask(sew_i);
    epc   = NB >> sew_i;
    sh    = 0;
    for (int unsigned j = 0; j < NB; j++) begin
      sh = (j < epc) ? (j << (3 + 32'(sew_i))) : 0;
      if (act_i[j] && (j < epc)) node[j] = pad[sh +: RV_XW] & smask;
      else                       node[j] = ident;
    end
    for (int unsigned k = 0; k < LVLS; k++) begin
      for (int unsigned i = 0; i < (NB >> (k + 1)); i++) begin
        node[i] = riscv_v_reduct_combine(op_i, sew_i, node[2*i], node[2*i+1]);
      end
    end
    fold_o = node[0][ELEN-1:0];
  end

endmodule

// File: rtl/riscv_v_reduct_seq.sv
// Multi-cycle vector reduction: walks vs2 one LANE_W chunk per cycle from the
// chunk holding vstart to the chunk holding vl-1, folding into an SEW accumulator.
module riscv_v_reduct_seq
  import riscv_v_pkg::*;
#(
  parameter int unsigned VLEN   = 128,
  parameter int unsigned ELEN   = 64,
  parameter int unsigned LANE_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  riscv_v_reduct_seq_if.slave bus
);

  localparam int unsigned NE  = VLEN / 8;
  localparam int unsigned NB  = LANE_W / 8;
  localparam int unsigned NCH = VLEN / LANE_W;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned LW  = $clog2(NB);

  riscv_v_reduct_state_e state_q, state_d;
  riscv_v_reduct_op_e    op_q, op_d;
  logic [1:0]            sew_q, sew_d;
  logic [VLEN-1:0]       vs2_q, vs2_d;
  logic [NE-1:0]         act_q, act_d;
  logic [CW-1:0]         chunk_q, chunk_d;
  logic [CW-1:0]         last_q, last_d;
  logic [RV_XW-1:0]      acc_q, acc_d;
  logic                  res_we_q, res_we_d;

  logic [LANE_W-1:0]     chunk_data;
  logic [NB-1:0]         chunk_act;
  logic [ELEN-1:0]       chunk_fold;
  logic [NE-1:0]         act_new;
  int unsigned           sh_new, sh_run, first_c, last_c;

  always_comb begin : chunk_sel
    sh_run     = LW - 32'(sew_q);
    chunk_data = vs2_q[32'(chunk_q) * LANE_W +: LANE_W];
    chunk_act  = act_q[(32'(chunk_q) << sh_run) +: NB] & ~({NB{1'b1}} << (NB >> sew_q));
  end

  riscv_v_reduct_chunk #(
    .LANE_W (LANE_W),
    .ELEN   (ELEN)
  ) u_chunk (
    .data_i (chunk_data),
    .act_i  (chunk_act),
    .op_i   (op_q),
    .sew_i  (sew_q),
    .fold_o (chunk_fold)
  );

  // Chunk range uses shifts by log2(EPC); last is clamped to the register.
  always_comb begin : accept_calc
    sh_new  = LW - 32'(bus.sew);
    first_c = 32'(bus.vstart) >> sh_new;
    last_c  = (32'(bus.vl) + (32'd1 << sh_new) - 32'd1) >> sh_new;
    last_c  = (last_c == 32'd0) ? 32'd0 : last_c - 32'd1;
    if (last_c > NCH - 1) last_c = NCH - 1;
    act_new = '0;
    for (int unsigned i = 0; i < NE; i++) begin
      act_new[i] = (i >= 32'(bus.vstart)) && (i < 32'(bus.vl)) &&
                   (!bus.use_mask || bus.mask[i]);
    end
  end

  always_comb begin : fsm_next
    state_d  = state_q;
    op_d     = op_q;
    sew_d    = sew_q;
    vs2_d    = vs2_q;
    act_d    = act_q;
    chunk_d  = chunk_q;
    last_d   = last_q;
    acc_d    = acc_q;
    res_we_d = res_we_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && !flush) begin
          op_d     = bus.op;
          sew_d    = bus.sew;
          vs2_d    = bus.vs2;
          act_d    = act_new;
          chunk_d  = CW'(first_c);
          last_d   = CW'(last_c);
          acc_d    = RV_XW'(bus.init) & riscv_v_sew_mask(bus.sew);
          res_we_d = 32'(bus.vstart) < 32'(bus.vl);
          state_d  = res_we_d ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d   = riscv_v_reduct_combine(op_q, sew_q, acc_q, RV_XW'(chunk_fold));
          chunk_d = chunk_q + 1'b1;
          if (chunk_q == last_q) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= RED_SUM;
      sew_q    <= '0;
      vs2_q    <= '0;
      act_q    <= '0;
      chunk_q  <= '0;
      last_q   <= '0;
      acc_q    <= '0;
      res_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sew_q    <= sew_d;
      vs2_q    <= vs2_d;
      act_q    <= act_d;
      chunk_q  <= chunk_d;
      last_q   <= last_d;
      acc_q    <= acc_d;
      res_we_q <= res_we_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.res_data  = acc_q[ELEN-1:0];
  assign bus.res_we    = res_we_q;

endmodule

// File: tb/tb_riscv_v_reduct_seq.sv
// Bench for riscv_v_reduct_seq: directed cases plus randomized ops against an
// element-by-element reference model.
module tb_riscv_v_reduct_seq;
  import riscv_v_pkg::*;

  localparam int unsigned VLEN = 128, ELEN = 64, LANE_W = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   tests = 0;
  int   fails = 0;

  riscv_v_reduct_seq_if #(.VLEN(VLEN), .ELEN(ELEN)) bus ();

  riscv_v_reduct_seq #(.VLEN(VLEN), .ELEN(ELEN), .LANE_W(LANE_W)) dut (
    .clk   (clk),
    .rst   (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_op(input riscv_v_reduct_op_e op, input int w,
                                         input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    sa = $signed(a << (64 - w)) >>> (64 - w);
    sb = $signed(b << (64 - w)) >>> (64 - w);
    case (op)
      RED_SUM:  return a + b;
      RED_AND:  return a & b;
      RED_OR:   return a | b;
      RED_XOR:  return a ^ b;
      RED_MAX:  return (sa > sb) ? a : b;
      RED_MAXU: return (a > b) ? a : b;
      RED_MIN:  return (sa < sb) ? a : b;
      default:  return (a < b) ? a : b;
    endcase
  endfunction

  function automatic logic [63:0] ref_reduce(input riscv_v_reduct_op_e op, input int sew,
                                             input logic [127:0] v, input logic [63:0] init,
                                             input logic [15:0] m, input bit um,
                                             input int vl, input int vs);
    int w;
    logic [63:0] msk, acc, e;
    logic [127:0] sh;
    w   = 8 << sew;
    msk = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    acc = init & msk;
    for (int i = vs; i < vl; i++) begin
      if (!um || m[i]) begin
        sh  = v >> (i * w);
        e   = sh[63:0] & msk;
        acc = ref_op(op, w, acc, e) & msk;
      end
    end
    return acc;
  endfunction

  function automatic int ref_lat(input int sew, input int vl, input int vs);
    int epc;
    epc = LANE_W / (8 << sew);
    if (vs < vl) return (vl + epc - 1) / epc - vs / epc + 1;
    return 1;
  endfunction

  // ---------------- drivers ----------------
  task automatic start_op(input riscv_v_reduct_op_e op, input logic [1:0] sew,
                          input logic [127:0] v, input logic [63:0] init,
                          input logic [15:0] m, input bit um,
                          input logic [4:0] vl, input logic [3:0] vs);
    @(negedge clk);
    bus.op       = op;
    bus.sew      = sew;
    bus.vs2      = v;
    bus.init     = init;
    bus.mask     = m;
    bus.use_mask = um;
    bus.vl       = vl;
    bus.vstart   = vs;
    bus.in_valid = 1'b1;
    @(posedge clk);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
    end while (!bus.out_valid && lat < 64);
    if (!bus.out_valid) lat = 999;
  endtask

  task automatic run_op(input riscv_v_reduct_op_e op, input logic [1:0] sew,
                        input logic [127:0] v, input logic [63:0] init,
                        input logic [15:0] m, input bit um,
                        input logic [4:0] vl, input logic [3:0] vs,
                        output logic [63:0] rd, output logic we, output int lat);
    bus.out_ready = 1'b1;
    start_op(op, sew, v, init, m, um, vl, vs);
    wait_done(lat);
    rd = bus.res_data;
    we = bus.res_we;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.res_data !== 64'd0 || bus.res_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b res_data=%h res_we=%b, expected 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.res_data, bus.res_we);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, expected 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    riscv_v_reduct_op_e op;
    logic [1:0] sew;
    logic [127:0] v;
    logic [63:0] init, exp_d, rd;
    logic [15:0] m;
    bit um;
    logic [4:0] vl;
    logic [3:0] vs;
    logic exp_we, we;
    int exp_lat, lat;
    for (int k = 0; k < 7; k++) begin
      m = '0; um = 1'b0; vs = '0; init = '0; v = '0; exp_we = 1'b1;
      op = RED_SUM; sew = 2'd0; vl = 5'd0; exp_d = '0; exp_lat = 1;
      case (k)
        0: begin sew = 2'd2; vl = 5'd4; v = {32'd4, 32'd3, 32'd2, 32'd1};
                 init = 64'd10; exp_d = 64'd20; exp_lat = 3; end
        1: begin op = RED_MAXU; vl = 5'd16; um = 1'b1; m = 16'h00FF;
                 for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(8'h10 + i);
                 v[127:120] = 8'hFF; exp_d = 64'h17; exp_lat = 3; end
        2: begin sew = 2'd1; vl = 5'd8; vs = 4'd5; v = {8{16'h0001}};
                 exp_d = 64'd3; exp_lat = 2; end
        3: begin sew = 2'd3; vl = 5'd0; init = 64'h1234_5678_9ABC_DEF0;
                 v = {4{$urandom}}; exp_d = init; exp_we = 1'b0; exp_lat = 1; end
        4: begin sew = 2'd1; vl = 5'd6; vs = 4'd6; init = 64'hABCD;
                 v = {4{$urandom}}; exp_d = 64'hABCD; exp_we = 1'b0; exp_lat = 1; end
        5: begin op = RED_MIN; sew = 2'd3; vl = 5'd2; init = 64'd7;
                 v = {64'd5, 64'h8000_0000_0000_0000};
                 exp_d = 64'h8000_0000_0000_0000; exp_lat = 3; end
        default: begin vl = 5'd2; v = {112'd0, 8'h02, 8'hFF};
                 exp_d = 64'h01; exp_lat = 2; end
      endcase
      run_op(op, sew, v, init, m, um, vl, vs, rd, we, lat);
      tests++;
      if (rd !== exp_d || we !== exp_we) begin
        fails++;
        $display("FAIL directed%0d_result: res_data=%h res_we=%b, expected %h %b",
                 k, rd, we, exp_d, exp_we);
      end
      tests++;
      if (lat != exp_lat) begin
        fails++;
        $display("FAIL directed%0d_latency: got %0d cycles, expected %0d", k, lat, exp_lat);
      end
    end
  endtask

  task automatic test_random();
    riscv_v_reduct_op_e op;
    int sew, vlmax, vl, vs, lat, exp_lat;
    logic [127:0] v;
    logic [63:0] init, rd, exp_d;
    logic [15:0] m;
    bit um;
    logic we;
    for (int n = 0; n < 60; n++) begin
      op    = riscv_v_reduct_op_e'($urandom_range(0, 7));
      sew   = $urandom_range(0, 3);
      vlmax = 16 >> sew;
      vl    = $urandom_range(0, vlmax);
      vs    = $urandom_range(0, (vlmax > 15) ? 15 : vlmax);
      v     = {$urandom, $urandom, $urandom, $urandom};
      init  = {$urandom, $urandom};
      m     = 16'($urandom);
      um    = 1'($urandom);
      exp_d   = ref_reduce(op, sew, v, init, m, um, vl, vs);
      exp_lat = ref_lat(sew, vl, vs);
      run_op(op, 2'(sew), v, init, m, um, 5'(vl), 4'(vs), rd, we, lat);
      tests++;
      if (rd !== exp_d || we !== (vs < vl) || lat != exp_lat) begin
        fails++;
        $display("FAIL random%0d op=%0d sew=%0d vl=%0d vs=%0d: res=%h we=%b lat=%0d, expected %h %b %0d",
                 n, op, sew, vl, vs, rd, we, lat, exp_d, (vs < vl), exp_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] v;
    logic [63:0] exp_d;
    int lat;
    bit bad;
    v = {$urandom, $urandom, $urandom, $urandom};
    exp_d = ref_reduce(RED_XOR, 1, v, 64'h5A5A, 16'h0, 1'b0, 8, 0);
    bus.out_ready = 1'b0;
    start_op(RED_XOR, 2'd1, v, 64'h5A5A, 16'h0, 1'b0, 5'd8, 4'd0);
    wait_done(lat);
    tests++;
    if (bus.res_data !== exp_d || lat != 3) begin
      fails++;
      $display("FAIL bp_result: res_data=%h lat=%0d, expected %h 3", bus.res_data, lat, exp_d);
    end
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.vs2 = ~v; bus.init = 64'hFFFF; bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.res_data !== exp_d || bus.res_we !== 1'b1) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL bp_hold: out_valid=%b in_ready=%b res_data=%h, expected 1 0 %h",
               bus.out_valid, bus.in_ready, bus.res_data, exp_d);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, expected 0 1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_flush();
    bit seen;
    int lat;
    bus.out_ready = 1'b1;
    start_op(RED_SUM, 2'd0, {4{$urandom}}, 64'd0, 16'h0, 1'b0, 5'd16, 4'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush = 1'b1;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL flush_accum_busy: in_ready=%b, expected 0", bus.in_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_accum_idle: in_ready=%b out_valid=%b, expected 1 0",
               bus.in_ready, bus.out_valid);
    end
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.out_valid !== 1'b0) seen = 1'b1; end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL flush_accum_no_valid: out_valid seen=1, expected 0");
    end
    // flush and request together: request must be dropped
    bus.in_valid = 1'b1;
    bus.vl = 5'd4;
    bus.vstart = 4'd0;
    flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush = 1'b0;
    seen = (bus.in_ready !== 1'b1);
    repeat (4) begin @(negedge clk); if (bus.out_valid !== 1'b0) seen = 1'b1; end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL flush_wins_accept: in_ready=%b out_valid=%b, expected 1 0",
               bus.in_ready, bus.out_valid);
    end
    // flush while result is waiting
    bus.out_ready = 1'b0;
    start_op(RED_OR, 2'd2, {4{$urandom}}, 64'h77, 16'h0, 1'b0, 5'd0, 4'd0);
    wait_done(lat);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++;
    if (lat != 1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_done: lat=%0d out_valid=%b in_ready=%b, expected 1 0 1",
               lat, bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [127:0] v;
    logic [63:0] rd, exp_d;
    logic we;
    int lat;
    bus.out_ready = 1'b1;
    start_op(RED_MAX, 2'd0, {4{$urandom}}, 64'h33, 16'h0, 1'b0, 5'd16, 4'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.res_data !== 64'd0 || bus.res_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b res_data=%h res_we=%b, expected 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.res_data, bus.res_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    v = {$urandom, $urandom, $urandom, $urandom};
    exp_d = ref_reduce(RED_MINU, 2, v, 64'hFFFF_FFFF, 16'h0, 1'b0, 3, 1);
    run_op(RED_MINU, 2'd2, v, 64'hFFFF_FFFF, 16'h0, 1'b0, 5'd3, 4'd1, rd, we, lat);
    tests++;
    if (rd !== exp_d || we !== 1'b1 || lat != 3) begin
      fails++;
      $display("FAIL reset_recover: res=%h we=%b lat=%0d, expected %h 1 3", rd, we, lat, exp_d);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] v;
    logic [63:0] rd, exp_d;
    logic we;
    int lat;
    for (int n = 0; n < 3; n++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      exp_d = ref_reduce(RED_AND, 3, v, 64'hFFFF_0000_FFFF_0000, 16'h0, 1'b0, 2, 0);
      run_op(RED_AND, 2'd3, v, 64'hFFFF_0000_FFFF_0000, 16'h0, 1'b0, 5'd2, 4'd0, rd, we, lat);
      tests++;
      if (rd !== exp_d || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL b2b%0d: res=%h in_ready=%b out_valid=%b, expected %h 1 0",
                 n, rd, bus.in_ready, bus.out_valid, exp_d);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = RED_SUM;
    bus.sew       = 2'd0;
    bus.vs2       = '0;
    bus.init      = '0;
    bus.mask      = '0;
    bus.use_mask  = 1'b0;
    bus.vl        = '0;
    bus.vstart    = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
